gpio_irq_dispatcher: RTL and testbench
======================================

Name: gpio_irq_dispatcher

Overview:
- Services the per-pin interrupt status vector of the GPIO controller.
- Picks one pending, unmasked pin with a round-robin scheduler and presents its index to a CPU/interrupt-fabric consumer over a valid/ready handshake.
- After the consumer accepts, issues a one-cycle clear pulse for that pin only, waits a fixed holdoff, then schedules the next pin.
- Sits between the GPIO controller's int_status/int_clear ports and the system interrupt controller.

Parameters:
- PIN_COUNT, 32, number of GPIO interrupt sources (2..64).
- ID_WIDTH, 5, width of irq_id; must equal ceil(log2(PIN_COUNT)).
- HOLDOFF, 2, idle cycles after a clear before rescheduling (0..15). Covers status-register update latency and level-source re-assertion.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scheduler may start a new selection.
- int_status  input  PIN_COUNT  pending interrupt bits from the GPIO controller.
- pin_mask  input  PIN_COUNT  1 = pin excluded from scheduling.
- int_clear  output  PIN_COUNT  one-hot clear pulse to the GPIO controller, registered.
- irq_valid  output  1  an interrupt index is being presented.
- irq_id  output  ID_WIDTH  index of the presented pin.
- irq_ready  input  1  consumer accepts irq_id when high together with irq_valid.
- pending_cnt  output  ID_WIDTH+1  popcount of (int_status & ~pin_mask), registered.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync-to-clk release):
  - int_clear=0, irq_valid=0, irq_id=0, pending_cnt=0, busy=0.
  - rr_ptr=0, holdoff counter=0, state=IDLE.
- Eligible vector: elig = int_status & ~pin_mask.
- Round-robin pick: lowest-index set bit of elig at index >= rr_ptr. If none, search from index 0, i.e. wrap-around. Combinational, evaluated in IDLE only.
- FSM states: IDLE, PRESENT, CLEAR, HOLD.
- IDLE:
  - If enable=1 and elig!=0: irq_id <= pick, irq_valid <= 1, go to PRESENT.
  - Latency: an eligible bit sampled in IDLE at edge N gives irq_valid=1 after edge N.
  - Otherwise stay in IDLE.
- PRESENT:
  - irq_valid stays 1 and irq_id stays stable until a handshake, i.e. irq_valid & irq_ready sampled at an edge.
  - No withdrawal: enable going low, the mask changing, or the status bit dropping do not deassert irq_valid.
  - On handshake:
    - irq_valid <= 0.
    - int_clear <= one-hot(irq_id).
    - rr_ptr <= irq_id+1, or 0 when irq_id == PIN_COUNT-1.
    - Go to CLEAR.
- CLEAR:
  - Exactly one cycle with int_clear one-hot high.
  - Then int_clear <= 0.
  - If HOLDOFF=0 go to IDLE; else load counter with HOLDOFF and go to HOLD.
- HOLD:
  - Counter decrements each cycle; go to IDLE when it reaches 1.
  - irq_valid stays 0 throughout.
- Back-to-back requests:
  - Minimum spacing between successive irq_valid rising edges is 3+HOLDOFF cycles, with ready tied high.
  - irq_ready high in IDLE/CLEAR/HOLD is ignored.
- enable:
  - Gates only new selections from IDLE.
  - A PRESENT in progress completes normally.
- pending_cnt:
  - Registered each cycle from elig, in all states, independent of enable.
  - 1-cycle latency.
  - Range 0..PIN_COUNT.
- busy = (state != IDLE), registered with the state.
- Reset mid-operation (any state): all outputs return to their reset values immediately; rr_ptr returns to 0; no partial int_clear pulse is emitted.
- Simultaneous events:
  - A new status bit arriving during PRESENT/CLEAR/HOLD is considered at the next IDLE.
  - The pin just cleared re-asserting (a level source) is eligible again after HOLD, but yields to higher-index pins because of rr_ptr.

Test Plan:
- Single pin: HOLDOFF=2, int_status=0x0000_0010, ready=1 -> irq_valid=1 with irq_id=4 one cycle later. After the handshake, int_clear=0x0000_0010 for exactly 1 cycle. irq_valid stays 0 for 3 cycles. pending_cnt=1.
- Round robin and wrap: int_status held at 0x8000_0003, status bits auto-cleared by the model -> irq_id sequence 0, 1, 31, then 0 after re-assertion. rr_ptr wraps from 31 to 0.
- Mask and enable: pin_mask=0x0000_0001, int_status=0x0000_0001 -> no irq_valid, pending_cnt=0. With the mask removed and enable=0 -> still no irq_valid. With enable=1 -> irq_id=0.
- Stall: int_status=0x0000_0100, ready=0 for 10 cycles -> irq_valid and irq_id=8 stable for all 10 cycles, int_clear=0. Raising ready -> clear pulse 0x0000_0100 on the next cycle.
- Reset mid-PRESENT: rst_n low while irq_valid=1, irq_id=8 -> same-cycle irq_valid=0, int_clear=0, busy=0. After release with status 0x0000_0300 -> irq_id=8 (rr_ptr=0).
- Level source re-assertion: pins 3 and 5 both held pending, HOLDOFF=0 -> alternates 3, 5, 3, 5. Spacing between irq_valid rising edges is 3 cycles with ready=1.

Source files
------------

// File: rtl/gpio_irq_dispatcher.sv
// rtl/gpio_irq_dispatcher.sv - round-robin GPIO interrupt dispatcher with clear pulse and holdoff
//
// Picks one pending, unmasked GPIO interrupt with a round-robin pointer and
// presents its index over a valid/ready handshake. Once the index is accepted,
// the block pulses int_clear for that pin only. It then idles for HOLDOFF
// cycles before scheduling again.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       allows new selections from IDLE
//   int_status   pending bits from the GPIO controller
//   pin_mask     1 = pin excluded from scheduling
//   int_clear    registered one-hot clear pulse to the GPIO controller
//   irq_valid    index presented to the consumer
//   irq_id       presented pin index
//   irq_ready    consumer accepts irq_id
//   pending_cnt  registered popcount of eligible pins
//   busy         scheduler not idle
module gpio_irq_dispatcher #(
    parameter int PIN_COUNT = 32,
    parameter int ID_WIDTH  = 5,
    parameter int HOLDOFF   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [PIN_COUNT-1:0] int_status,
    input  logic [PIN_COUNT-1:0] pin_mask,
    output logic [PIN_COUNT-1:0] int_clear,
    output logic                 irq_valid,
    output logic [ID_WIDTH-1:0]  irq_id,
    input  logic                 irq_ready,
    output logic [ID_WIDTH:0]    pending_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        CLEAR   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(PIN_COUNT - 1);
    localparam logic [3:0]           HOLD_INIT = 4'(HOLDOFF);
    localparam logic [PIN_COUNT-1:0] ONE_HOT0  = PIN_COUNT'(1);

    state_t                 state_q, state_d;
    logic [PIN_COUNT-1:0]   clear_q, clear_d;
    logic                   valid_q, valid_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [ID_WIDTH-1:0]    rr_q, rr_d;
    logic [ID_WIDTH:0]      cnt_q, cnt_d;
    logic [3:0]             hold_q, hold_d;
    logic                   busy_q, busy_d;

    logic [PIN_COUNT-1:0]   elig;
    logic [ID_WIDTH-1:0]    pick_hi, pick_lo, pick;
    logic                   hi_found;

    assign elig = int_status & ~pin_mask;

    // Scan from the top down so the last hit is the lowest index. pick_hi is
    // the lowest hit at or above rr_q; pick_lo is the lowest hit overall and
    // serves as the wrap-around choice.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        hi_found = 1'b0;
        for (int i = PIN_COUNT - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick_lo = ID_WIDTH'(i);
                if (ID_WIDTH'(i) >= rr_q) begin
                    pick_hi  = ID_WIDTH'(i);
                    hi_found = 1'b1;
                end
            end
        end
        pick = hi_found ? pick_hi : pick_lo;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < PIN_COUNT; i++) begin
            cnt_d = cnt_d + {{ID_WIDTH{1'b0}}, elig[i]};
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        clear_d = '0;
        case (state_q)
            IDLE: begin
                if (enable && (elig != '0)) begin
                    id_d    = pick;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // No withdrawal: only the handshake ends the presentation.
                if (irq_ready) begin
                    valid_d = 1'b0;
                    clear_d = ONE_HOT0 << id_q;
                    rr_d    = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (HOLDOFF == 0) begin
                    state_d = IDLE;
                end else begin
                    hold_d  = HOLD_INIT;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                hold_d = hold_q - 4'd1;
                if (hold_q <= 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            clear_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
        end
    end

    assign int_clear   = clear_q;
    assign irq_valid   = valid_q;
    assign irq_id      = id_q;
    assign pending_cnt = cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_gpio_irq_dispatcher.sv
// tb/tb_gpio_irq_dispatcher.sv - self-checking bench for gpio_irq_dispatcher
module tb_gpio_irq_dispatcher;

    localparam int PC = 32;
    localparam int HO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        irq_ready = 1'b0;
    logic [31:0] int_status = '0;
    logic [31:0] pin_mask = '0;
    logic [31:0] int_clear;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic [5:0]  pending_cnt;
    logic        busy;

    logic [31:0] h0_clear;
    logic        h0_valid;
    logic [4:0]  h0_id;
    logic [5:0]  h0_cnt;
    logic        h0_busy;

    gpio_irq_dispatcher #(.PIN_COUNT(PC), .ID_WIDTH(5), .HOLDOFF(HO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .int_status(int_status),
        .pin_mask(pin_mask), .int_clear(int_clear), .irq_valid(irq_valid),
        .irq_id(irq_id), .irq_ready(irq_ready), .pending_cnt(pending_cnt), .busy(busy)
    );

    gpio_irq_dispatcher #(.PIN_COUNT(PC), .ID_WIDTH(5), .HOLDOFF(0)) dut_h0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .int_status(int_status),
        .pin_mask(pin_mask), .int_clear(h0_clear), .irq_valid(h0_valid),
        .irq_id(h0_id), .irq_ready(irq_ready), .pending_cnt(h0_cnt), .busy(h0_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // GPIO controller stand-in: latched bits drop on int_clear, level bits stay.
    logic [31:0] gpio_lat = '0;
    logic [31:0] gpio_lvl = '0;

    // Behavioural model: timestamps instead of states. free_at is the first
    // edge at which a new selection may be made after an accepted request.
    logic        m_valid = 1'b0;
    logic [4:0]  m_id = '0;
    logic [31:0] m_clear = '0;
    int          m_cnt = 0;
    logic        m_busy = 1'b0;
    int          rr = 0;
    int          free_at = 0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [31:0] elig;
        logic [31:0] nclr;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_id    = '0;
            m_clear = '0;
            m_cnt   = 0;
            m_busy  = 1'b0;
            rr      = 0;
            free_at = 0;
        end else begin
            elig = int_status & ~pin_mask;
            nclr = '0;
            if (m_valid) begin
                if (irq_ready) begin
                    nclr    = 32'h1 << m_id;
                    rr      = (int'(m_id) + 1) % PC;
                    free_at = cyc + 2 + HO;
                    m_valid = 1'b0;
                end
            end else if (cyc >= free_at && enable && elig != 0) begin
                for (int k = 0; k < PC; k++) begin
                    int idx = (rr + k) % PC;
                    if (elig[idx]) begin
                        m_id    = 5'(idx);
                        m_valid = 1'b1;
                        break;
                    end
                end
            end
            m_clear = nclr;
            m_cnt   = $countones(elig);
            m_busy  = m_valid || (cyc + 1 < free_at);
        end
        cyc++;
    endtask

    task automatic compare();
        chk("valid", irq_valid, m_valid);
        if (m_valid) chk("id", irq_id, m_id);
        chk("clear", int_clear, m_clear);
        chk("pending", pending_cnt, m_cnt);
        chk("busy", busy, m_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
        gpio_lat   = gpio_lat & ~int_clear;
        int_status = gpio_lat | gpio_lvl;
    endtask

    task automatic set_gpio(input logic [31:0] lat, input logic [31:0] lvl);
        gpio_lat   = lat;
        gpio_lvl   = lvl;
        int_status = lat | lvl;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!irq_valid && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, irq_valid, 1'b1);
    endtask

    task automatic take_one(input string name, output int id);
        wait_valid(name);
        id = irq_valid ? int'(irq_id) : -1;
        if (irq_valid) tick();
    endtask

    int          got;
    int          lowcnt;
    int          exp_ids[4];
    int          q_id[$], q_cy[$], h_id[$], h_cy[$];
    logic        pv, ph;
    logic [31:0] clr_or;

    initial begin
        // reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_valid", irq_valid, 1'b0);
        chk("rst_id", irq_id, 5'd0);
        chk("rst_clear", int_clear, 32'h0);
        chk("rst_pending", pending_cnt, 6'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_h0_busy", h0_busy, 1'b0);
        rst_n = 1'b1;

        // single pin
        enable = 1'b1;
        irq_ready = 1'b1;
        set_gpio(32'h0000_0010, 32'h0);
        tick();
        chk("t1_valid", irq_valid, 1'b1);
        chk("t1_id", irq_id, 5'd4);
        chk("t1_pend", pending_cnt, 6'd1);
        tick();
        chk("t1_clear", int_clear, 32'h0000_0010);
        chk("t1_valid_low", irq_valid, 1'b0);
        lowcnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) chk("t1_clear_1cyc", int_clear, 32'h0);
            if (!irq_valid) lowcnt++;
        end
        chk("t1_quiet", lowcnt, 3);
        chk("t1_pend0", pending_cnt, 6'd0);

        // round robin with wrap
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_gpio(32'h8000_0003, 32'h0);
        take_one("t2_a", got); chk("t2_id_a", got, 0);
        take_one("t2_b", got); chk("t2_id_b", got, 1);
        take_one("t2_c", got); chk("t2_id_c", got, 31);
        set_gpio(32'h0000_0003, 32'h0);
        take_one("t2_d", got); chk("t2_id_d", got, 0);
        take_one("t2_e", got); chk("t2_id_e", got, 1);

        // mask and enable
        set_gpio(32'h0, 32'h0);
        repeat (6) tick();
        pin_mask = 32'h1;
        set_gpio(32'h0, 32'h1);
        repeat (4) tick();
        chk("t3_masked_valid", irq_valid, 1'b0);
        chk("t3_masked_pend", pending_cnt, 6'd0);
        pin_mask = 32'h0;
        enable = 1'b0;
        repeat (4) tick();
        chk("t3_dis_valid", irq_valid, 1'b0);
        chk("t3_dis_pend", pending_cnt, 6'd1);
        enable = 1'b1;
        tick();
        chk("t3_en_valid", irq_valid, 1'b1);
        chk("t3_en_id", irq_id, 5'd0);
        tick();
        set_gpio(32'h0, 32'h0);
        repeat (6) tick();

        // stall
        irq_ready = 1'b0;
        set_gpio(32'h0000_0100, 32'h0);
        wait_valid("t4");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_stall_valid", irq_valid, 1'b1);
            chk("t4_stall_id", irq_id, 5'd8);
            chk("t4_stall_clear", int_clear, 32'h0);
        end
        irq_ready = 1'b1;
        tick();
        chk("t4_clear", int_clear, 32'h0000_0100);
        tick();
        chk("t4_clear_end", int_clear, 32'h0);
        repeat (6) tick();

        // reset while presenting
        irq_ready = 1'b0;
        set_gpio(32'h0000_0100, 32'h0);
        wait_valid("t5");
        chk("t5_pre_id", irq_id, 5'd8);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", irq_valid, 1'b0);
        chk("t5_rst_clear", int_clear, 32'h0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_id", irq_id, 5'd0);
        tick();
        set_gpio(32'h0000_0300, 32'h0);
        irq_ready = 1'b1;
        rst_n = 1'b1;
        take_one("t5_a", got); chk("t5_id_a", got, 8);
        take_one("t5_b", got); chk("t5_id_b", got, 9);
        repeat (6) tick();

        // level sources 3 and 5, both holdoff variants
        rst_n = 1'b0;
        tick();
        set_gpio(32'h0, 32'h0000_0028);
        rst_n = 1'b1;
        pv = 1'b0;
        ph = 1'b0;
        clr_or = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (irq_valid && !pv) begin q_id.push_back(int'(irq_id)); q_cy.push_back(cyc); end
            if (h0_valid && !ph) begin h_id.push_back(int'(h0_id)); h_cy.push_back(cyc); end
            pv = irq_valid;
            ph = h0_valid;
            clr_or = clr_or | h0_clear;
        end
        exp_ids = '{3, 5, 3, 5};
        chk("t6_cnt", q_id.size() >= 4, 1'b1);
        chk("t6_h0_cnt", h_id.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (q_id.size() > i) chk("t6_id", q_id[i], exp_ids[i]);
            if (h_id.size() > i) chk("t6_h0_id", h_id[i], exp_ids[i]);
            if (i > 0 && q_cy.size() > i) chk("t6_gap", q_cy[i] - q_cy[i-1], 3 + HO);
            if (i > 0 && h_cy.size() > i) chk("t6_h0_gap", h_cy[i] - h_cy[i-1], 3);
        end
        chk("t6_h0_clr", clr_or, 32'h0000_0028);
        chk("t6_h0_pend", h0_cnt, 6'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
